// File: rtl/completion_ram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : completion_ram_writer_pkg
// Desc    : Shared state encoding, error bit indices and dword-enable popcount
//           for the completion RAM writer.
// Rev     : 1.0 - initial release
// ============================================================================
package completion_ram_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int c_err_overrun  = 0;
  localparam int c_err_misalign = 1;
  localparam int c_err_timeout  = 2;

  localparam int c_dw_per_beat = 256 / 32;
  // Widest bus handled by the popcount helper (2048-bit beat).
  localparam int c_max_dw = 64;

  function automatic logic [6:0] popcount_dw(input logic [c_max_dw-1:0] dw_en);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < c_max_dw; i++) begin
      cnt = cnt + {6'd0, dw_en[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/completion_be_mask.sv
`default_nettype none
// ============================================================================
// Module  : completion_be_mask
// Desc    : Counts dwords in a beat, clips them to the remaining length and
//           substitutes the last-dword byte enables on the final dword.
// Rev     : 1.0 - initial release
// ============================================================================
module completion_be_mask
  import completion_ram_writer_pkg::*;
#(
  parameter int NVME_DATA_WIDTH = 256,
  parameter int LEN_WIDTH       = 12
) (
  input  logic [NVME_DATA_WIDTH/8-1:0] i_be,
  input  logic [LEN_WIDTH-1:0]         i_remaining,
  input  logic [3:0]                   i_lbe,
  input  logic                         i_last,
  output logic [LEN_WIDTH-1:0]         o_beat_dw,
  output logic [LEN_WIDTH-1:0]         o_wr_dw,
  output logic [NVME_DATA_WIDTH/8-1:0] o_wr_be
);

  localparam int c_dw = NVME_DATA_WIDTH / 32;

  logic [c_max_dw-1:0] w_dw_en;

  for (genvar gi = 0; gi < c_max_dw; gi++) begin : g_dw_en
    if (gi < c_dw) begin : g_used
      assign w_dw_en[gi] = |i_be[4*gi +: 4];
    end else begin : g_pad
      assign w_dw_en[gi] = 1'b0;
    end
  end

  assign o_beat_dw = LEN_WIDTH'(popcount_dw(w_dw_en));
  assign o_wr_dw   = (o_beat_dw > i_remaining) ? i_remaining : o_beat_dw;

  always_comb begin
    o_wr_be = '0;
    for (int i = 0; i < c_dw; i++) begin
      if (LEN_WIDTH'(i) < o_wr_dw) begin
        o_wr_be[4*i +: 4] = i_be[4*i +: 4];
      end
      if (i_last && (LEN_WIDTH'(i) == o_wr_dw - LEN_WIDTH'(1))) begin
        o_wr_be[4*i +: 4] = i_lbe;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/completion_ram_writer.sv
`default_nettype none
// ============================================================================
// Module  : completion_ram_writer
// Desc    : Writes a realigned completion stream into the data buffer RAM and
//           reports one status word per read command. Optional idle timeout
//           is enabled with the CPL_TIMEOUT_EN macro.
// Rev     : 1.0 - initial release
// ============================================================================
module completion_ram_writer
  import completion_ram_writer_pkg::*;
#(
  parameter int NVME_DATA_WIDTH = 256,
  parameter int RAM_ADDR_WIDTH  = 10,
  parameter int LEN_WIDTH       = 12,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         srst,
  input  logic                         cmd_valid,
  input  logic [RAM_ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  output logic                         cmd_ready,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic                         in_eof,
  input  logic [3:0]                   in_lbe,
  input  logic [NVME_DATA_WIDTH/8-1:0] in_be,
  input  logic [NVME_DATA_WIDTH-1:0]   in_data,
  output logic                         in_ready,
  output logic                         ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [NVME_DATA_WIDTH/8-1:0] ram_wr_be,
  output logic [NVME_DATA_WIDTH-1:0]   ram_wr_data,
  output logic                         done_valid,
  output logic [LEN_WIDTH-1:0]         done_len,
  output logic [2:0]                   done_err,
  input  logic                         done_ready
);

  localparam logic [LEN_WIDTH-1:0] c_dw_full = LEN_WIDTH'(NVME_DATA_WIDTH / 32);

  state_t                      r_state, w_state_nxt;
  logic [RAM_ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [LEN_WIDTH-1:0]        r_remaining, r_done_len;
  logic [2:0]                  r_err;
  logic [3:0]                  r_lbe;

  logic                        w_cmd_acc, w_beat_acc, w_last, w_term, w_timeout;
  logic [LEN_WIDTH-1:0]        w_cmd_len, w_beat_dw, w_wr_dw, w_rem_after;
  logic [NVME_DATA_WIDTH/8-1:0] w_wr_be;
  logic [3:0]                  w_lbe;

  assign w_cmd_acc   = cmd_valid & cmd_ready;
  assign w_beat_acc  = in_valid & in_ready;
  assign w_cmd_len   = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
  // The sof beat carries its own lbe; later beats of the TLP use the latched copy.
  assign w_lbe       = in_sof ? in_lbe : r_lbe;
  assign w_last      = (r_remaining != '0) && (w_beat_dw >= r_remaining);
  assign w_rem_after = r_remaining - w_wr_dw;
  assign w_term      = w_beat_acc && in_eof && (w_rem_after == '0);

  completion_be_mask #(
    .NVME_DATA_WIDTH (NVME_DATA_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH)
  ) u_be_mask (
    .i_be        (in_be),
    .i_remaining (r_remaining),
    .i_lbe       (w_lbe),
    .i_last      (w_last),
    .o_beat_dw   (w_beat_dw),
    .o_wr_dw     (w_wr_dw),
    .o_wr_be     (w_wr_be)
  );

`ifdef CPL_TIMEOUT_EN
  localparam logic [LEN_WIDTH+3:0] c_timeout = (LEN_WIDTH+4)'(TIMEOUT_CYCLES);
  logic [LEN_WIDTH+3:0] r_idle;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle <= '0;
    end else if (srst || (r_state != ST_WRITE) || w_beat_acc) begin
      r_idle <= '0;
    end else if (r_idle != c_timeout) begin
      r_idle <= r_idle + (LEN_WIDTH+4)'(1);
    end
  end

  assign w_timeout = (r_state == ST_WRITE) && !w_beat_acc && (r_idle == c_timeout);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else if (srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid)            w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_term || w_timeout)  w_state_nxt = ST_DONE;
      ST_DONE:  if (done_ready)           w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    done_valid = 1'b0;
    case (r_state)
      ST_IDLE:  cmd_ready  = 1'b1;
      ST_WRITE: in_ready   = 1'b1;
      ST_DONE:  done_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_done_len  <= '0;
      r_err       <= '0;
      r_lbe       <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_be   <= '0;
      ram_wr_data <= '0;
    end else if (srst) begin
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_done_len  <= '0;
      r_err       <= '0;
      r_lbe       <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_be   <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      if (w_cmd_acc) begin
        r_wr_ptr    <= cmd_addr;
        r_remaining <= w_cmd_len;
        r_done_len  <= '0;
        r_err       <= '0;
      end
      if (w_beat_acc) begin
        r_wr_ptr    <= r_wr_ptr + RAM_ADDR_WIDTH'(1);
        r_remaining <= w_rem_after;
        r_done_len  <= r_done_len + w_wr_dw;
        if (in_sof) r_lbe <= in_lbe;
        if (w_beat_dw > r_remaining) r_err[c_err_overrun] <= 1'b1;
        if (in_eof && (w_beat_dw < c_dw_full) && (w_rem_after != '0)) begin
          r_err[c_err_misalign] <= 1'b1;
        end
        ram_wr_en   <= (w_wr_dw != '0);
        ram_wr_addr <= r_wr_ptr;
        ram_wr_be   <= w_wr_be;
        ram_wr_data <= in_data;
      end
      if (w_timeout) r_err[c_err_timeout] <= 1'b1;
    end
  end

  assign done_len = r_done_len;
  assign done_err = r_err;

endmodule
`default_nettype wire

// File: doc/completion_ram_writer.md
Name: completion_ram_writer

Overview:
Sits directly downstream of the completer data insertion stage. Consumes its realigned NVMe-width completion stream (sof/eof/lbe/be/data) and writes it into the local data buffer RAM at a base address supplied per read command. Tracks dwords received against the expected length across multiple completion TLPs, then reports one status word per command.

Parameters:
NVME_DATA_WIDTH, 256, data bus and RAM word width in bits; DW_PER_BEAT = NVME_DATA_WIDTH/32.
RAM_ADDR_WIDTH, 10, RAM word address width; one RAM word is one beat.
LEN_WIDTH, 12, command length width in dwords.
TIMEOUT_CYCLES, 65535, idle-cycle limit; used only with CPL_TIMEOUT_EN.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_addr  in  RAM_ADDR_WIDTH  RAM base word address
cmd_len  in  LEN_WIDTH  expected dwords; 0 is illegal and treated as 1
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
in_valid / in_sof / in_eof  in  1 each  stream from the insertion stage
in_lbe  in  4  last-dword byte enables, valid on sof
in_be  in  NVME_DATA_WIDTH/8  byte enables, contiguous from dword 0
in_data  in  NVME_DATA_WIDTH  payload
in_ready  out  1  stream ready
ram_wr_en  out  1  RAM write strobe
ram_wr_addr  out  RAM_ADDR_WIDTH  RAM word address
ram_wr_be  out  NVME_DATA_WIDTH/8  RAM byte write enables
ram_wr_data  out  NVME_DATA_WIDTH  RAM write data
done_valid  out  1  status available
done_len  out  LEN_WIDTH  dwords actually written
done_err  out  3  [0] overrun, [1] misalign, [2] timeout
done_ready  in  1  status consumed

Behaviour:
- Reset (rstn low or srst high): state IDLE. All outputs are 0, except cmd_ready = 1 in IDLE. Counters and error flags are cleared. Asserting either reset mid-command abandons the command and emits no status.
- FSM:
  - IDLE: cmd_ready=1. On cmd accept: latch addr to wr_ptr, latch len to remaining, clear done_len and errors; go to WRITE.
  - WRITE: in_ready=1. Each accepted beat is processed as below.
  - DONE: done_valid=1. When done_ready is high, go to IDLE.
- cmd_ready=0 and in_ready=0 outside the states listed above.
- Per accepted beat:
  - beat_dw = number of set 4-bit groups in in_be (contiguous, 1..DW_PER_BEAT).
  - wr_dw = min(beat_dw, remaining).
  - If beat_dw > remaining, set overrun. Dwords beyond remaining are masked out of ram_wr_be, but the beat is still consumed.
  - ram_wr_be = in_be restricted to the first wr_dw dwords.
  - If this beat contains the command's final dword, that dword's 4 byte enables are replaced by the latched in_lbe of the current completion.
  - remaining -= wr_dw; done_len += wr_dw; wr_ptr increments by 1 per beat, wrapping modulo 2^RAM_ADDR_WIDTH.
- RAM write timing: ram_wr_* are registered, one cycle after beat accept. ram_wr_en is a single-cycle pulse per beat. When wr_dw = 0 (pure overrun beat), ram_wr_en is not asserted.
- Misalign: a partial beat (beat_dw < DW_PER_BEAT) on eof while remaining after the beat > 0 sets misalign. The RAM write still occurs.
- Command termination: an eof beat with remaining after the beat = 0 goes to DONE on the next cycle. After that eof, in_ready deasserts.
- Simultaneous events: done_ready with done_valid and a new cmd_valid in the same cycle → status is consumed that cycle; the new command is accepted the following cycle (IDLE).
- done_len and done_err are held stable while done_valid is high.

Optional Feature:
Macro CPL_TIMEOUT_EN.
- With the macro defined:
  - A LEN_WIDTH+4-bit idle counter runs in WRITE. It clears on every accepted beat.
  - On reaching TIMEOUT_CYCLES it sets done_err[2] and forces DONE with the current done_len.
  - Any following stray beats see in_ready=0.
- Without the macro: no counter exists, and done_err[2] is tied to 0.

Decomposition:
- Shared package: state encoding (IDLE/WRITE/DONE), done_err bit index constants, DW_PER_BEAT, and a popcount-of-dword-enables function.
- One natural sub-module: completion_be_mask. It is combinational: in_be, remaining, lbe, last flag → wr_dw and masked ram_wr_be. Instantiated once.

Test Plan:
- cmd addr=0x010, len=16; two full beats, eof on the second; lbe=0xF → ram writes at 0x010 and 0x011 with all-ones be; done_len=16; done_err=0.
- cmd len=13; completion 1 = one full beat with eof; completion 2 = beat with be for 5 dw, lbe=0x3 → second write be has dwords 0-3 all-ones and dword4 = 0x3; done_len=13; err=0.
- cmd len=6; one 8-dw eof beat → ram_wr_be covers dwords 0-5 only; done_len=6; done_err=3'b001.
- cmd len=16; first completion eof beat with 4 dw, then one 8-dw and one 4-dw beat → done_err[1]=1; done_len=16.
- Assert rstn low mid-WRITE after one beat → all outputs 0; state IDLE; cmd_ready=1 after release; no done_valid.
- CPL_TIMEOUT_EN, TIMEOUT_CYCLES=100: cmd len=16, one beat then silence → done_valid at 100 idle cycles; done_len=8; done_err=3'b100.
